// File: rtl/noc_packet_injector.sv
// Credit-based NoC flit injector: host FIFO, packet framing and end-of-application.
// Packets are header, size, then `size` payload flits.
module noc_packet_injector #(
    parameter int FLIT_SIZE  = 32,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 src_valid_i,
    output logic                 src_ready_o,
    input  logic [FLIT_SIZE-1:0] src_data_i,
    input  logic                 src_eoa_i,
    output logic                 tx_o,
    input  logic                 credit_i,
    output logic [FLIT_SIZE-1:0] data_o,
    output logic                 eoa_o,
    output logic [CNT_WIDTH-1:0] pkt_count_o,
    output logic                 busy_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = FIFO_DEPTH[AW:0];

    typedef enum logic [1:0] {
        HEADER,
        SIZE,
        PAYLOAD
    } state_t;

    logic [FLIT_SIZE-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [AW:0]          count;
    logic                 full;
    logic                 empty;
    logic                 wr_en;
    logic                 rd_en;
    state_t               state;
    logic [CNT_WIDTH-1:0] remaining;
    logic [CNT_WIDTH-1:0] pkt_count;
    logic [CNT_WIDTH-1:0] size_f;
    logic                 eoa_req;
    logic                 eoa_q;

    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);

    // Ready is held low during reset; no write bypass when full.
    assign src_ready_o = rst_ni && !full;
    assign wr_en       = src_valid_i && src_ready_o;

    assign tx_o   = !empty;
    assign data_o = empty ? '0 : mem[rd_ptr];
    assign rd_en  = tx_o && credit_i;

    assign size_f      = data_o[CNT_WIDTH-1:0];
    assign pkt_count_o = pkt_count;
    assign eoa_o       = eoa_q;
    assign busy_o      = !empty || (state != HEADER);

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wr_ptr] <= src_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({wr_en, rd_en})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Framing only advances on flits actually accepted by the NoC.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= HEADER;
            remaining <= '0;
            pkt_count <= '0;
        end else if (rd_en) begin
            unique case (state)
                HEADER: begin
                    state <= SIZE;
                end
                SIZE: begin
                    remaining <= size_f;
                    if (size_f == '0) begin
                        pkt_count <= pkt_count + CNT_WIDTH'(1);
                        state     <= HEADER;
                    end else begin
                        state <= PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    remaining <= remaining - CNT_WIDTH'(1);
                    if (remaining == CNT_WIDTH'(1)) begin
                        pkt_count <= pkt_count + CNT_WIDTH'(1);
                        state     <= HEADER;
                    end
                end
                default: begin
                    state <= HEADER;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            eoa_req <= 1'b0;
            eoa_q   <= 1'b0;
        end else begin
            if (src_eoa_i) begin
                eoa_req <= 1'b1;
            end
            if (eoa_req && empty && (state == HEADER)) begin
                eoa_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_noc_packet_injector.sv
// Randomized and directed bench for noc_packet_injector.
// A stream-level model (flit queue, packet parse) predicts every output each cycle.
module tb_noc_packet_injector;

    localparam int DEPTH = 16;

    logic        clk;
    logic        rst_n;
    logic        src_valid;
    logic        src_ready;
    logic [31:0] src_data;
    logic        src_eoa;
    logic        tx;
    logic        credit;
    logic [31:0] data;
    logic        eoa;
    logic [15:0] pkt_count;
    logic        busy;

    noc_packet_injector #(
        .FLIT_SIZE (32),
        .FIFO_DEPTH(DEPTH),
        .CNT_WIDTH (16)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .src_valid_i(src_valid),
        .src_ready_o(src_ready),
        .src_data_i (src_data),
        .src_eoa_i  (src_eoa),
        .tx_o       (tx),
        .credit_i   (credit),
        .data_o     (data),
        .eoa_o      (eoa),
        .pkt_count_o(pkt_count),
        .busy_o     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] q[$];
    logic [31:0] pkt[$];
    logic [31:0] sq[$];
    logic [15:0] cnt_m;
    bit          latch_m;
    bit          eoa_m;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        q.delete();
        pkt.delete();
        sq.delete();
        cnt_m   = '0;
        latch_m = 0;
        eoa_m   = 0;
    endtask

    task automatic check_all();
        chk("src_ready", 32'(src_ready), 32'(q.size() < DEPTH));
        chk("tx", 32'(tx), 32'(q.size() != 0));
        chk("data", data, (q.size() != 0) ? q[0] : 32'h0);
        chk("busy", 32'(busy), 32'(q.size() != 0 || pkt.size() != 0));
        chk("pkt_count", 32'(pkt_count), 32'(cnt_m));
        chk("eoa", 32'(eoa), 32'(eoa_m));
    endtask

    // Entered at posedge+1; leaves at the next posedge+1.
    task automatic step(input bit v, input logic [31:0] d, input bit c,
                        input bit e, output bit acc);
        bit          rd;
        bit          eoa_nx;
        logic [31:0] sz;
        src_valid = v;
        src_data  = d;
        credit    = c;
        src_eoa   = e;
        #1;
        check_all();
        acc    = v && (q.size() < DEPTH);
        rd     = (q.size() != 0) && c;
        eoa_nx = eoa_m || (latch_m && q.size() == 0 && pkt.size() == 0);
        @(posedge clk);
        #1;
        if (rd) begin
            pkt.push_back(q.pop_front());
            if (pkt.size() >= 2) begin
                sz = pkt[1];
                if (pkt.size() == int'(sz[15:0]) + 2) begin
                    cnt_m++;
                    pkt.delete();
                end
            end
        end
        if (acc) q.push_back(d);
        eoa_m = eoa_nx;
        if (e) latch_m = 1;
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) step(0, 32'h0, 1, 0, acc);
    endtask

    // mode 0: credit always; 1: credit every other cycle; 2: random valid and credit
    task automatic run(input int mode, input int max_cyc);
        bit acc;
        bit v;
        bit c;
        int n;
        n = 0;
        while ((sq.size() != 0 || q.size() != 0) && n < max_cyc) begin
            v = (sq.size() != 0);
            c = 1;
            case (mode)
                1: c = n[0];
                2: begin
                    c = ($urandom_range(0, 3) != 0);
                    v = v && ($urandom_range(0, 3) != 0);
                end
                default: ;
            endcase
            step(v, v ? sq[0] : 32'h0, c, 0, acc);
            if (acc) void'(sq.pop_front());
            n++;
        end
        chk("drain_done", 32'(sq.size() + q.size()), 32'h0);
    endtask

    task automatic chk_reset_vals();
        chk("rst_src_ready", 32'(src_ready), 32'h0);
        chk("rst_tx", 32'(tx), 32'h0);
        chk("rst_data", data, 32'h0);
        chk("rst_eoa", 32'(eoa), 32'h0);
        chk("rst_pkt_count", 32'(pkt_count), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit          acc;
        logic [31:0] hdr;
        int          sz;

        rst_n     = 1'b0;
        src_valid = 1'b0;
        src_data  = '0;
        src_eoa   = 1'b0;
        credit    = 1'b1;
        model_clear();
        #2;
        chk_reset_vals();
        release_reset();
        idle(2);

        // Basic packet, full credit
        sq = '{32'h0000_0102, 32'h0000_0002, 32'hAAAA_0001, 32'hAAAA_0002};
        run(0, 50);
        idle(2);
        chk("pkt1_count", 32'(pkt_count), 32'h1);

        // Same packet, credit toggling
        sq = '{32'h0000_0102, 32'h0000_0002, 32'hAAAA_0001, 32'hAAAA_0002};
        run(1, 50);
        idle(2);

        // Zero-size packets back to back
        sq = '{32'h10, 32'h0, 32'h20, 32'h0};
        run(0, 50);
        idle(2);

        // Fill past depth with credit withheld
        sq.push_back(32'h300);
        sq.push_back(32'd15);
        for (int i = 0; i < 15; i++) sq.push_back(32'hC000_0000 + i);
        for (int i = 0; i < 18; i++) begin
            step(sq.size() != 0, (sq.size() != 0) ? sq[0] : 32'h0, 0, 0, acc);
            if (acc) void'(sq.pop_front());
        end
        chk("fill_refused_left", 32'(sq.size()), 32'h1);
        run(0, 100);
        idle(2);

        // Randomized well-formed packets
        for (int p = 0; p < 12; p++) begin
            hdr = $urandom;
            sz  = $urandom_range(0, 6);
            sq.push_back(hdr);
            sq.push_back({$urandom_range(0, 65535) & 32'hFFFF_0000} | 32'(sz));
            for (int k = 0; k < sz; k++) sq.push_back($urandom);
        end
        run(2, 3000);
        idle(2);

        // EOA pulsed with three payload flits outstanding
        sq = '{32'h700, 32'd5, 32'hE1, 32'hE2};
        run(0, 50);
        step(0, 32'h0, 1, 1, acc);
        idle(3);
        sq = '{32'hE3, 32'hE4, 32'hE5};
        run(0, 50);
        idle(3);
        chk("eoa_set", 32'(eoa), 32'h1);

        // Flits after EOA keep it high
        sq = '{32'h800, 32'h0};
        run(0, 50);
        idle(2);

        // Reset in the middle of a payload
        sq = '{32'h900, 32'd6, 32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6};
        for (int i = 0; i < 5; i++) begin
            step(sq.size() != 0, sq[0], 1, 0, acc);
            if (acc) void'(sq.pop_front());
        end
        chk("mid_busy", 32'(busy), 32'h1);
        rst_n = 1'b0;
        #1;
        chk_reset_vals();
        model_clear();
        src_valid = 1'b0;
        release_reset();
        sq = '{32'hA00, 32'd1, 32'hBEEF};
        run(0, 50);
        idle(2);
        chk("post_rst_count", 32'(pkt_count), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
